// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the default datapath width.
package mult_div_unit_pkg;

    localparam int MD_DATA_W = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mult_div_unit_if #(parameter int DATA_W = 32);
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult_div_unit_md_iter_core.sv
// CALC datapath: shared add/subtract, product/remainder shift register and
// iteration counter; operates on unsigned magnitudes only.
module mult_div_unit_md_iter_core #(
    parameter int DATA_W = 32,
    parameter int ITER   = DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  is_div,
    input  logic [DATA_W-1:0]     a_mag,
    input  logic [DATA_W-1:0]     b_mag,
    output logic                  last,
    output logic [2*DATA_W-1:0]   acc
);
    localparam int CW = $clog2(ITER);

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W:0]     rem_sh, add_x, add_y;
    logic [DATA_W+1:0]   sum;

    always_comb begin
        // Divide: trial subtract via x + ~y + 1; carry out means remainder >= divisor.
        rem_sh = acc_q[2*DATA_W-1:DATA_W-1];
        add_x  = is_div ? rem_sh : {1'b0, acc_q[2*DATA_W-1:DATA_W]};
        add_y  = is_div ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
        sum    = {1'b0, add_x} + {1'b0, add_y} + {{(DATA_W+1){1'b0}}, is_div};

        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        if (load) begin
            acc_d  = {{DATA_W{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_d = is_div ? b_mag : a_mag;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (is_div) begin
                acc_d = sum[DATA_W+1] ? {sum[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                                      : {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
            end else begin
                acc_d = acc_q[0] ? {sum[DATA_W:0], acc_q[DATA_W-1:1]}
                                 : {1'b0, acc_q[2*DATA_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last = step && (cnt_q == CW'(ITER - 1));
    assign acc  = acc_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with private HI/LO: FSM, sign pre/post-processing
// and the architectural HI/LO registers around the shift-add/restoring core.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W,
    parameter int ITER   = DATA_W
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    md_state_e           state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic                is_div_q, is_div_d, is_signed_q, is_signed_d;
    logic                res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
    logic                done_q, done_d;
    logic                load, step, last;
    logic [DATA_W-1:0]   a_mag, b_mag, quo, rem;
    logic [2*DATA_W-1:0] acc, prod;

    assign a_mag = (is_signed_q && a_q[DATA_W-1]) ? -a_q : a_q;
    assign b_mag = (is_signed_q && b_q[DATA_W-1]) ? -b_q : b_q;

    mult_div_unit_md_iter_core #(.DATA_W(DATA_W), .ITER(ITER)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .is_div (is_div_q),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .last   (last),
        .acc    (acc)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        res_neg_d   = res_neg_q;
        rem_neg_d   = rem_neg_q;
        done_d      = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        prod        = res_neg_q ? -acc : acc;
        quo         = res_neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rem         = rem_neg_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            a_d         = bus.a;
                            b_d         = bus.b;
                            is_div_d    = bus.op[1];
                            is_signed_d = ~bus.op[0];
                            state_d     = ST_PREP;
                        end
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_PREP: begin
                res_neg_d = is_signed_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                rem_neg_d = is_signed_q & a_q[DATA_W-1];
                load      = 1'b1;
                state_d   = ST_CALC;
            end
            ST_CALC: begin
                step = 1'b1;
                if (last) state_d = ST_FIX;
            end
            ST_FIX: begin
                // Divide by zero bypasses sign correction: all-ones quotient, raw dividend.
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = quo;
                    hi_d = rem;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            res_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            res_neg_q   <= res_neg_d;
            rem_neg_q   <= rem_neg_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes reference results, a monitor
// pops and compares on every done pulse and checks HI/LO stability while busy.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_div_unit_if #(.DATA_W(32)) bus();

    mult_div_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    int          busy_run = 0;
    bit          prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from integer arithmetic: returns {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx, sy, q, r, p;
        logic [63:0] up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MD_MULT: begin
                p = sx * sy;
                return p;
            end
            MD_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                return up;
            end
            MD_DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every done pulse against the scoreboard head.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_run  = 0;
                prev_done = 1'b0;
            end else begin
                if (bus.done) begin
                    chk("done_single_cycle", {63'b0, prev_done}, 64'd0);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done actual=done_pulse expected=no_pulse t=%0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result_hi", {32'b0, bus.hi}, {32'b0, e[63:32]});
                        chk("result_lo", {32'b0, bus.lo}, {32'b0, e[31:0]});
                        chk("busy_cycles", 64'(busy_run), 64'd34);
                        model_hi = e[63:32];
                        model_lo = e[31:0];
                    end
                    busy_run = 0;
                end else if (bus.busy) begin
                    busy_run++;
                    chk("hi_stable_busy", {32'b0, bus.hi}, {32'b0, model_hi});
                    chk("lo_stable_busy", {32'b0, bus.lo}, {32'b0, model_lo});
                end else begin
                    busy_run = 0;
                end
                prev_done = bus.done;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("wait_idle_timeout", 64'(bus.busy), 64'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        wait_idle();
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        if (o <= MD_DIVU) exp_q.push_back(ref_model(o, x, y));
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom_range(0, 7));
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (o <= MD_DIVU) chk("busy_after_start", 64'(bus.busy), 64'd1);
        if (o == MD_MTHI) begin
            chk("mthi_hi", {32'b0, bus.hi}, {32'b0, x});
            chk("mthi_no_busy", 64'(bus.busy), 64'd0);
            model_hi = x;
        end
        if (o == MD_MTLO) begin
            chk("mtlo_lo", {32'b0, bus.lo}, {32'b0, x});
            chk("mtlo_no_busy", 64'(bus.busy), 64'd0);
            model_lo = x;
        end
    endtask

    task automatic poke(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_hi", {32'b0, bus.hi}, 64'd0);
        chk("reset_lo", {32'b0, bus.lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MD_MULT,  32'hFFFF_FFFD, 32'd7);
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);
        issue(MD_DIVU,  32'd7, 32'd0);
        issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        issue(MD_DIV,   32'hFFFF_FFF9, 32'd0);
        drain();

        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        repeat (3) @(negedge clk);
        chk("mthi_busy_low", 64'(bus.busy), 64'd0);

        // Writes attempted while busy must leave the operation and HI/LO untouched.
        issue(MD_DIVU, 32'd1000, 32'd33);
        repeat (5) @(negedge clk);
        poke(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
        poke(MD_MTHI, 32'hCAFE_F00D, 32'd0);
        poke(MD_MULT, 32'd9, 32'd9);
        drain();

        // Asynchronous reset in the middle of CALC.
        issue(MD_MULT, 32'h0001_2345, 32'hFFFF_0007);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_hi", {32'b0, bus.hi}, 64'd0);
        chk("async_rst_lo", {32'b0, bus.lo}, 64'd0);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(MD_MULTU, 32'd3, 32'd5);
        drain();

        // Back-to-back: new DIVU accepted in the done cycle of a MULTU.
        issue(MD_MULTU, 32'h0000_BEEF, 32'h0001_0001);
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 64'(bus.done), 64'd1);
        issue(MD_DIVU, 32'd100, 32'd7);
        drain();

        for (int i = 0; i < 30; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(o, pick(), pick());
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
